// File: rtl/run_ctrl_if.sv
// Command/status bundle between an operator front end and the run-control sequencer.
// The master drives opcode and command pulses; the slave returns enable and status.
interface run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       instruct;
    logic             start;
    logic             step;
    logic             stop;
    logic             clk_en;
    logic             running;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output instruct, start, step, stop,
        input  clk_en, running, halted, timeout, cycle_cnt
    );

    modport slave (
        input  instruct, start, step, stop,
        output clk_en, running, halted, timeout, cycle_cnt
    );
endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer: turns start/step/stop commands and the current opcode into a
// core clock enable, parks on the halt opcode, counts executed cycles, enforces a runaway limit.
module run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    run_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_RESUME = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0]       OP_HALT  = 2'b10;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CYCLES);
    localparam bit               LIMIT_ON = (MAX_CYCLES != 0);

    state_t           state_reg;
    logic             running_reg;
    logic             halted_reg;
    logic             timeout_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic is_halt;
    logic limit_hit;
    logic clk_en_next;

    assign is_halt   = (bus.instruct == OP_HALT);
    assign limit_hit = LIMIT_ON && (cnt_reg == LIMIT);

    // Enable is decoded straight from state so an async reset kills it without an edge.
    always_comb begin
        clk_en_next = 1'b0;
        case (state_reg)
            S_RUN:    clk_en_next = !is_halt && !limit_hit;
            S_STEP:   clk_en_next = !is_halt;
            S_RESUME: clk_en_next = 1'b1;
            default:  clk_en_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            running_reg <= 1'b0;
            halted_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            if (clk_en_next && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    if (bus.stop) begin
                        state_reg <= S_IDLE;
                    end else if (bus.step) begin
                        state_reg <= S_STEP;
                    end else if (bus.start) begin
                        state_reg   <= S_RUN;
                        running_reg <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_reg   <= S_IDLE;
                        running_reg <= 1'b0;
                    end else if (is_halt) begin
                        state_reg   <= S_HALTED;
                        running_reg <= 1'b0;
                        halted_reg  <= 1'b1;
                    end else if (limit_hit) begin
                        state_reg   <= S_HALTED;
                        running_reg <= 1'b0;
                        halted_reg  <= 1'b1;
                        timeout_reg <= 1'b1;
                    end
                end
                S_STEP: begin
                    state_reg  <= is_halt ? S_HALTED : S_IDLE;
                    halted_reg <= is_halt;
                end
                S_HALTED: begin
                    // A timed-out core stays parked until reset; only stop can leave.
                    if (bus.stop) begin
                        state_reg  <= S_IDLE;
                        halted_reg <= 1'b0;
                    end else if (bus.start && !timeout_reg) begin
                        state_reg   <= S_RESUME;
                        running_reg <= 1'b1;
                        halted_reg  <= 1'b0;
                    end
                end
                S_RESUME: begin
                    state_reg   <= S_RUN;
                    running_reg <= 1'b1;
                end
                default: begin
                    state_reg   <= S_IDLE;
                    running_reg <= 1'b0;
                    halted_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_en    = clk_en_next;
    assign bus.running   = running_reg;
    assign bus.halted    = halted_reg;
    assign bus.timeout   = timeout_reg;
    assign bus.cycle_cnt = cnt_reg;
endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a vector table for the main sequencer plus hand-written
// sequences for the runaway limit, counter saturation and asynchronous reset.
module tb_run_ctrl;
    logic clk;
    logic rst_n;

    run_ctrl_if #(.CNT_W(16)) m_if ();
    run_ctrl_if #(.CNT_W(16)) l_if ();
    run_ctrl_if #(.CNT_W(3))  s_if ();

    run_ctrl #(.CNT_W(16), .MAX_CYCLES(0)) dut     (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    run_ctrl #(.CNT_W(16), .MAX_CYCLES(4)) dut_lim (.clk(clk), .rst_n(rst_n), .bus(l_if.slave));
    run_ctrl #(.CNT_W(3),  .MAX_CYCLES(0)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       so;
        logic [1:0] ins;
        logic       en;
        logic       run;
        logic       hlt;
        logic       to;
        int         cnt;
    } vec_t;

    vec_t vt[34];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic so, input logic [1:0] ins,
                                input logic en, input logic run, input logic hlt, input logic to,
                                input int cnt);
        vec_t v;
        v.st = st; v.sp = sp; v.so = so; v.ins = ins;
        v.en = en; v.run = run; v.hlt = hlt; v.to = to; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive_m(input logic st, input logic sp, input logic so, input logic [1:0] ins);
        m_if.start = st; m_if.step = sp; m_if.stop = so; m_if.instruct = ins;
    endtask

    task automatic drive_l(input logic st, input logic [1:0] ins);
        l_if.start = st; l_if.step = 1'b0; l_if.stop = 1'b0; l_if.instruct = ins;
    endtask

    task automatic drive_s(input logic st, input logic [1:0] ins);
        s_if.start = st; s_if.step = 1'b0; s_if.stop = 1'b0; s_if.instruct = ins;
    endtask

    // Advance to just after the next rising edge, where inputs are updated.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int pulses;
    string nm;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive_m(0, 0, 0, 2'b00);
        drive_l(0, 2'b00);
        drive_s(0, 2'b00);

        // start,step,stop,instruct | clk_en,running,halted,timeout,cycle_cnt (same cycle)
        vt[0]  = mk(1,0,0,2'b00, 0,0,0,0,0);
        vt[1]  = mk(0,0,0,2'b00, 1,1,0,0,0);
        vt[2]  = mk(0,0,0,2'b00, 1,1,0,0,1);
        vt[3]  = mk(0,0,0,2'b00, 1,1,0,0,2);
        vt[4]  = mk(0,0,0,2'b00, 1,1,0,0,3);
        vt[5]  = mk(0,0,0,2'b00, 1,1,0,0,4);
        vt[6]  = mk(0,0,0,2'b10, 0,1,0,0,5);
        vt[7]  = mk(0,0,0,2'b10, 0,0,1,0,5);
        vt[8]  = mk(1,0,0,2'b10, 0,0,1,0,5);
        vt[9]  = mk(0,0,0,2'b10, 1,1,0,0,5);
        vt[10] = mk(0,0,0,2'b10, 0,1,0,0,6);
        vt[11] = mk(0,0,0,2'b10, 0,0,1,0,6);
        vt[12] = mk(0,0,1,2'b00, 0,0,1,0,6);
        vt[13] = mk(0,1,0,2'b01, 0,0,0,0,6);
        vt[14] = mk(0,0,0,2'b01, 1,0,0,0,6);
        vt[15] = mk(0,1,0,2'b01, 0,0,0,0,7);
        vt[16] = mk(0,0,0,2'b01, 1,0,0,0,7);
        vt[17] = mk(0,1,0,2'b01, 0,0,0,0,8);
        vt[18] = mk(0,0,0,2'b01, 1,0,0,0,8);
        vt[19] = mk(0,1,0,2'b10, 0,0,0,0,9);
        vt[20] = mk(0,0,0,2'b10, 0,0,0,0,9);
        vt[21] = mk(0,1,0,2'b00, 0,0,1,0,9);
        vt[22] = mk(0,0,0,2'b00, 0,0,1,0,9);
        vt[23] = mk(0,0,1,2'b00, 0,0,1,0,9);
        vt[24] = mk(1,0,1,2'b00, 0,0,0,0,9);
        vt[25] = mk(1,1,1,2'b00, 0,0,0,0,9);
        vt[26] = mk(1,0,0,2'b00, 0,0,0,0,9);
        vt[27] = mk(0,1,0,2'b00, 1,1,0,0,9);
        vt[28] = mk(0,0,1,2'b00, 1,1,0,0,10);
        vt[29] = mk(0,0,0,2'b00, 0,0,0,0,11);
        vt[30] = mk(0,0,0,2'b00, 0,0,0,0,11);
        vt[31] = mk(1,1,0,2'b01, 0,0,0,0,11);
        vt[32] = mk(0,0,0,2'b01, 1,0,0,0,11);
        vt[33] = mk(0,0,0,2'b00, 0,0,0,0,12);

        #22;
        chk("rst_clk_en",  m_if.clk_en,    0);
        chk("rst_running", m_if.running,   0);
        chk("rst_halted",  m_if.halted,    0);
        chk("rst_timeout", m_if.timeout,   0);
        chk("rst_cnt",     m_if.cycle_cnt, 0);
        rst_n = 1'b1;

        // Runaway limit of 4 on dut_lim.
        next_cycle();
        drive_l(1, 2'b00);
        next_cycle();
        drive_l(0, 2'b00);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (l_if.clk_en) pulses++;
            next_cycle();
        end
        chk("lim_pulses",  pulses,         4);
        chk("lim_halted",  l_if.halted,    1);
        chk("lim_timeout", l_if.timeout,   1);
        chk("lim_cnt",     l_if.cycle_cnt, 4);
        drive_l(1, 2'b00);
        next_cycle();
        drive_l(0, 2'b00);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (l_if.clk_en) pulses++;
            next_cycle();
        end
        chk("lim_restart_pulses", pulses,         0);
        chk("lim_restart_halted", l_if.halted,    1);
        chk("lim_restart_cnt",    l_if.cycle_cnt, 4);

        // Main vector table.
        for (int i = 0; i < 34; i++) begin
            next_cycle();
            drive_m(vt[i].st, vt[i].sp, vt[i].so, vt[i].ins);
            #1;
            $display("vec %0d: st=%0b sp=%0b so=%0b ins=%b -> en=%0b run=%0b hlt=%0b to=%0b cnt=%0d",
                     i, vt[i].st, vt[i].sp, vt[i].so, vt[i].ins, m_if.clk_en, m_if.running,
                     m_if.halted, m_if.timeout, m_if.cycle_cnt);
            nm = $sformatf("vec%0d_clk_en", i);  chk(nm, m_if.clk_en,    vt[i].en);
            nm = $sformatf("vec%0d_running", i); chk(nm, m_if.running,   vt[i].run);
            nm = $sformatf("vec%0d_halted", i);  chk(nm, m_if.halted,    vt[i].hlt);
            nm = $sformatf("vec%0d_timeout", i); chk(nm, m_if.timeout,   vt[i].to);
            nm = $sformatf("vec%0d_cnt", i);     chk(nm, m_if.cycle_cnt, vt[i].cnt);
        end
        next_cycle();
        drive_m(0, 0, 0, 2'b00);

        // 3-bit counter saturates at 7.
        drive_s(1, 2'b00);
        next_cycle();
        drive_s(0, 2'b00);
        for (int i = 0; i < 12; i++) next_cycle();
        #1;
        chk("sat_cnt",    s_if.cycle_cnt, 7);
        chk("sat_clk_en", s_if.clk_en,    1);
        chk("sat_run",    s_if.running,   1);

        // Asynchronous reset in the middle of a RUN cycle.
        drive_m(1, 0, 0, 2'b00);
        next_cycle();
        drive_m(0, 0, 0, 2'b00);
        next_cycle();
        next_cycle();
        #2;
        chk("arst_pre_clk_en", m_if.clk_en, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_clk_en",   m_if.clk_en,    0);
        chk("arst_cnt",      m_if.cycle_cnt, 0);
        chk("arst_running",  m_if.running,   0);
        chk("arst_lim_to",   l_if.timeout,   0);
        chk("arst_lim_halt", l_if.halted,    0);
        chk("arst_sat_cnt",  s_if.cycle_cnt, 0);
        next_cycle();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            if (m_if.clk_en || m_if.running) pulses++;
        end
        chk("post_rst_idle", pulses,         0);
        chk("post_rst_cnt",  m_if.cycle_cnt, 0);
        drive_m(1, 0, 0, 2'b00);
        next_cycle();
        drive_m(0, 0, 0, 2'b00);
        #1;
        chk("post_rst_start_en",  m_if.clk_en,  1);
        chk("post_rst_start_run", m_if.running, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control sequencer for the paper processor core, acting as the driving end of the halt/clock-gating path. It decides on every cycle whether the core may advance, by producing a clock enable from operator commands (start, step, stop) and the current 2-bit opcode. It enters a halted state on the halt opcode and resumes past a halted instruction on command. It also counts executed cycles and enforces an optional runaway limit.

## Interface
- CNT_W, 16: width of the executed-cycle counter.
- MAX_CYCLES, 0: runaway limit on executed cycles; 0 disables the limit; a nonzero value must be ≤ 2^CNT_W − 1.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instruct  in  2  opcode of the instruction currently at PC; 2'b10 = halt.
- start  in  1  one-cycle pulse: begin or resume free-running execution.
- step  in  1  one-cycle pulse: execute exactly one instruction.
- stop  in  1  one-cycle pulse: abandon free-running execution.
- clk_en  out  1  core advance enable for this cycle.
- running  out  1  high in RUN or RESUME.
- halted  out  1  high in HALTED.
- timeout  out  1  sticky; set when the runaway limit is hit.
- cycle_cnt  out  CNT_W  number of cycles with clk_en = 1.

## Operation
- States: IDLE, RUN, STEP, RESUME, HALTED. Encoding is free.
- On reset: state IDLE; cycle_cnt = 0; timeout = 0. Consequently clk_en = running = halted = 0.
- Command priority in any cycle: stop > step > start.
- IDLE:
  - stop → IDLE.
  - step → STEP.
  - start → RUN.
- RUN:
  - stop → IDLE.
  - instruct == 2'b10 → HALTED.
  - limit hit → HALTED with timeout set.
  - otherwise stay in RUN. step and start are ignored.
- STEP: single-cycle state. Next state is HALTED if instruct == 2'b10, otherwise IDLE. All commands are ignored.
- HALTED:
  - start with timeout = 0 → RESUME.
  - stop → IDLE.
  - step is ignored. start with timeout = 1 is ignored.
- RESUME: single-cycle state, then RUN. All commands are ignored. This state exists so the core steps past the halt instruction it is parked on.
- clk_en is combinational from state, instruct and cycle_cnt:
  - RUN: 1 when instruct ≠ 2'b10 and the limit is not hit.
  - STEP: 1 when instruct ≠ 2'b10.
  - RESUME: 1 regardless of instruct.
  - IDLE and HALTED: 0.
- Limit hit: MAX_CYCLES ≠ 0 and cycle_cnt == MAX_CYCLES.
- cycle_cnt: increments by 1 on every edge where clk_en = 1. Saturates at all-ones with no wrap. Cleared only by reset.
- timeout: set on entry to HALTED via the limit. Cleared only by reset.

## Timing
- Halt opcode in RUN: clk_en drops in the same cycle instruct shows 2'b10, so the halt instruction never executes. halted rises on the next edge.
- start in IDLE at edge N: RUN from N+1; the first clk_en = 1 is in cycle N+1.
- start in HALTED: RESUME for exactly one cycle, with clk_en = 1 and cycle_cnt incremented. RUN follows from the next cycle.
- step: exactly one clk_en pulse, or none if instruct == 2'b10. Back in IDLE (or HALTED) one cycle later.
- stop in RUN at edge N: clk_en = 0 from cycle N+1 onward.
- Asynchronous rst_n assertion mid-RUN, STEP or RESUME: clk_en falls immediately, with no wait for an edge. All outputs go to their reset values.
- Deassert rst_n synchronously to clk externally; this block does not resynchronize it.

## Test plan
- Reset, then start with instruct = 2'b00 for 5 cycles and 2'b10 on the 6th → 5 clk_en pulses, cycle_cnt = 5, halted = 1, clk_en = 0 during the halt cycle.
- From that HALTED state, start with instruct held at 2'b10 → exactly one clk_en pulse (RESUME), cycle_cnt = 6. Then RUN resumes and halts again on the next cycle, because instruct is still 2'b10.
- Three step pulses in IDLE with instruct = 2'b01 → three isolated clk_en pulses and cycle_cnt = 3. A step with instruct = 2'b10 → no pulse, halted = 1.
- Simultaneous start and stop in IDLE → stays IDLE. Stop two cycles after start → exactly 2 clk_en pulses.
- MAX_CYCLES = 4, start with instruct = 2'b00 → 4 pulses, then halted = 1 and timeout = 1. A later start is ignored. rst_n low clears everything.
- rst_n asserted mid-RUN, asynchronously between edges → clk_en low at once, cycle_cnt = 0. After release the block sits in IDLE until start.
